mips_pc_sig_gen: RTL and testbench

- Sits directly downstream of the CPU core inside mips_cpu_fpga and produces the 1-bit mips_cpu_pc_sig board output.
- Accepts the stream of retired PC values through a valid/ready handshake and buffers them in a small FIFO.
- Serializes each PC as a framed bit stream on mips_cpu_pc_sig.
- Folds every accepted PC into a 32-bit MISR signature, which the bench reads for end-of-run comparison.

---
 rtl/mips_pc_sig_gen.sv | 120 ++++++++++++
 tb/tb_mips_pc_sig_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_pc_sig_gen.sv
// mips_pc_sig_gen: buffers retired PCs, serializes each as a framed bit stream and folds every PC into a MISR.
// Define MIPS_PC_SIG_PARITY_EN to append an odd-parity bit between the data bits and the stop bit.
module mips_pc_sig_gen #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          BIT_CYCLES = 1,
  parameter logic [31:0] MISR_POLY  = 32'h04C11DB7
) (
  input  logic                        sys_clk,
  input  logic                        sys_reset_n,
  input  logic                        pc_valid,
  input  logic [31:0]                 pc,
  output logic                        pc_ready,
  output logic                        mips_cpu_pc_sig,
  output logic [31:0]                 misr_value,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(BIT_CYCLES) + 1;
  localparam logic [TW-1:0] T_LOAD = TW'(BIT_CYCLES - 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
`ifdef MIPS_PC_SIG_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t        state_q, state_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   misr_q, misr_d, shift_q, shift_d;
  logic [4:0]    idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          sig_q, sig_d, busy_q, par_q, par_d;
  logic          push, pop, tick;
  assign pc_ready        = cnt_q != FULL;
  assign push            = pc_valid && pc_ready;
  assign pop             = state_q == IDLE && cnt_q != '0;
  assign tick            = tmr_q == '0;
  assign cnt_d           = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign misr_d          = push ? {misr_q[30:0], 1'b0} ^ (misr_q[31] ? MISR_POLY : 32'h0) ^ pc : misr_q;
  assign mips_cpu_pc_sig = sig_q;
  assign busy            = busy_q;
  assign misr_value      = misr_q;
  assign fifo_count      = cnt_q;
  // sig_d encodes the current state's line level; registering it gives the two-cycle push-to-START latency
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tmr_d   = tick ? T_LOAD : tmr_q - 1'b1;
    sig_d   = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d = T_LOAD;
        if (pop) begin
          state_d = START;
          shift_d = mem_q[rd_q];
          par_d   = ~^mem_q[rd_q];
          idx_d   = 5'd31;
        end
      end
      START: begin
        sig_d = 1'b1;
        if (tick) state_d = DATA;
      end
      DATA: begin
        sig_d = shift_q[31];
        if (tick) begin
          shift_d = {shift_q[30:0], 1'b0};
          idx_d   = idx_q - 5'd1;
`ifdef MIPS_PC_SIG_PARITY_EN
          if (idx_q == 5'd0) state_d = PARITY;
`else
          if (idx_q == 5'd0) state_d = STOP;
`endif
        end
      end
`ifdef MIPS_PC_SIG_PARITY_EN
      PARITY: begin
        sig_d = par_q;
        if (tick) state_d = STOP;
      end
`endif
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      misr_q  <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
      sig_q   <= 1'b0;
      busy_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      cnt_q   <= cnt_d;
      misr_q  <= misr_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      sig_q   <= sig_d;
      busy_q  <= state_d != IDLE;
      par_q   <= par_d;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_q] <= pc;
  end
endmodule

// File: tb/tb_mips_pc_sig_gen.sv
// tb_mips_pc_sig_gen: directed scoreboard bench; a frame monitor decodes mips_cpu_pc_sig against queued PCs.
module tb_mips_pc_sig_gen;
`ifdef MIPS_PC_SIG_PARITY_EN
  localparam int FRAME = 35;
`else
  localparam int FRAME = 34;
`endif
  logic        sys_clk = 1'b0, sys_reset_n = 1'b0, pc_valid = 1'b0;
  logic [31:0] pc = '0;
  logic        pc_ready, mips_cpu_pc_sig, busy;
  logic [31:0] misr_value;
  logic [2:0]  fifo_count;
  int          nvec = 0, nerr = 0, cyc = 0, push_cyc = 0, stop_cyc = 0, mbit = 0;
  logic [31:0] exp_q[$];
  int          start_q[$];
  logic [31:0] misr_m = '0, msh = '0;
  logic        mon_act = 1'b0, mpar = 1'b0;

  mips_pc_sig_gen dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .pc_valid(pc_valid), .pc(pc),
    .pc_ready(pc_ready), .mips_cpu_pc_sig(mips_cpu_pc_sig), .misr_value(misr_value),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // frame decoder: start bit, 32 data bits MSB first, optional parity, stop bit
  always @(negedge sys_clk) begin
    if (!sys_reset_n) mon_act = 1'b0;
    else if (!mon_act) begin
      if (mips_cpu_pc_sig) begin
        mon_act = 1'b1;
        mbit = 0;
        start_q.push_back(cyc);
      end
    end else if (mbit < 32) begin
      msh = {msh[30:0], mips_cpu_pc_sig};
      mbit++;
`ifdef MIPS_PC_SIG_PARITY_EN
    end else if (mbit == 32) begin
      mpar = mips_cpu_pc_sig;
      check("parity_bit", {31'b0, mips_cpu_pc_sig}, {31'b0, ~^msh});
      mbit++;
`endif
    end else begin
      stop_cyc = cyc;
      mon_act = 1'b0;
      check("stop_bit", {31'b0, mips_cpu_pc_sig}, 32'h0);
      check("frame_expected", 32'(exp_q.size() != 0), 32'h1);
      if (exp_q.size() != 0) check("frame_data", msh, exp_q.pop_front());
    end
  end

  task automatic push(input logic [31:0] v);
    int n = 0;
    pc = v;
    pc_valid = 1'b1;
    while (!pc_ready && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    check("push_wait_timeout", 32'(n >= 200), 32'h0);
    @(posedge sys_clk);
    #1;
    push_cyc = cyc;
    exp_q.push_back(v);
    misr_m = {misr_m[30:0], 1'b0} ^ (misr_m[31] ? 32'h04C11DB7 : 32'h0) ^ v;
    check("misr_after_push", misr_value, misr_m);
    @(negedge sys_clk);
    pc_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || mon_act || fifo_count != 0) && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    check("drain_timeout", 32'(n >= 3000), 32'h0);
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic apply_reset();
    sys_reset_n = 1'b0;
    pc_valid = 1'b0;
    exp_q.delete();
    start_q.delete();
    misr_m = '0;
    repeat (2) @(negedge sys_clk);
    sys_reset_n = 1'b1;
    @(negedge sys_clk);
  endtask

  initial begin
    int n, bad;
    @(negedge sys_clk);
    check("rst_sig", {31'b0, mips_cpu_pc_sig}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_count", {29'b0, fifo_count}, 32'h0);
    check("rst_ready", {31'b0, pc_ready}, 32'h1);
    check("rst_misr", misr_value, 32'h0);
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (mips_cpu_pc_sig !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("idle_activity", 32'(bad), 32'h0);
    check("idle_ready", {31'b0, pc_ready}, 32'h1);
    check("idle_count", {29'b0, fifo_count}, 32'h0);
    check("idle_misr", misr_value, 32'h0);

    // single frame
    push(32'h00000004);
    check("single_misr", misr_value, 32'h00000004);
    repeat (10) @(negedge sys_clk);
    check("single_busy", {31'b0, busy}, 32'h1);
    check("single_count", {29'b0, fifo_count}, 32'h0);
    drain();
    check("single_frames", 32'(start_q.size()), 32'h1);
    check("single_latency", 32'(start_q[0] - push_cyc), 32'h2);
    check("single_length", 32'(stop_cyc - start_q[0]), 32'(FRAME - 1));
    check("single_idle_busy", {31'b0, busy}, 32'h0);

    // burst filling the FIFO, then a push held while full
    start_q.delete();
    push(32'h0);
    push(32'h4);
    push(32'h8);
    push(32'hC);
    push(32'h10);
    check("burst_full_count", {29'b0, fifo_count}, 32'h4);
    check("burst_full_ready", {31'b0, pc_ready}, 32'h0);
    pc = 32'h14;
    pc_valid = 1'b1;
    repeat (5) @(negedge sys_clk);
    check("full_hold_misr", misr_value, misr_m);
    check("full_hold_count", {29'b0, fifo_count}, 32'h4);
    push(32'h14);
    drain();
    check("burst_frames", 32'(start_q.size()), 32'h6);
    for (int i = 1; i < 6; i++) check("burst_period", 32'(start_q[i] - start_q[i-1]), 32'(FRAME + 1));

    // MISR feedback path
    apply_reset();
    push(32'h80000000);
    check("misr_msb", misr_value, 32'h80000000);
    push(32'h0);
    check("misr_feedback", misr_value, 32'h04C11DB7);
    drain();

    // reset in the middle of a frame with FIFO content pending
    push(32'hAAAA5555);
    push(32'h1);
    push(32'h2);
    n = 0;
    while (!(mon_act && mbit >= 10) && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    check("midrst_wait_timeout", 32'(n >= 200), 32'h0);
    check("midrst_busy_before", {31'b0, busy}, 32'h1);
    sys_reset_n = 1'b0;
    #1;
    check("midrst_sig", {31'b0, mips_cpu_pc_sig}, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_count", {29'b0, fifo_count}, 32'h0);
    check("midrst_ready", {31'b0, pc_ready}, 32'h1);
    check("midrst_misr", misr_value, 32'h0);
    exp_q.delete();
    start_q.delete();
    misr_m = '0;
    repeat (2) @(negedge sys_clk);
    sys_reset_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge sys_clk);
      if (mips_cpu_pc_sig !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("midrst_residual", 32'(bad), 32'h0);
    check("midrst_frames", 32'(start_q.size()), 32'h0);

`ifdef MIPS_PC_SIG_PARITY_EN
    start_q.delete();
    push(32'h00000003);
    drain();
    check("parity_value", {31'b0, mpar}, 32'h1);
    check("parity_length", 32'(stop_cyc - start_q[0]), 32'(FRAME - 1));
`endif

    check("final_queue", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
